// File: rtl/ProcessorTypes.sv
// Shared types and constants for the CSR / trap / privilege controller.
//   Privilege     : privilege level encoding (U=0, S=1, M=3)
//   TrapInfo      : trap request from the register-write stage
//   csr_xstatus_t : bit layout of mstatus (sstatus is a masked view of it)
//   CSR_*         : implemented CSR addresses
//   *_MASK        : writable-field masks
package ProcessorTypes;

  typedef enum logic [1:0] {
    PRIV_U = 2'd0,
    PRIV_S = 2'd1,
    PRIV_M = 2'd3
  } Privilege;

  typedef struct packed {
    logic        valid;
    logic        isInterrupt;
    logic [3:0]  cause;
    logic [31:0] value;
  } TrapInfo;

  typedef struct packed {
    logic [8:0] rsv31;  // 31:23
    logic       tsr;    // 22
    logic [1:0] rsv21;  // 21:20
    logic       mxr;    // 19
    logic       sum;    // 18
    logic [4:0] rsv17;  // 17:13
    logic [1:0] mpp;    // 12:11
    logic [1:0] rsv10;  // 10:9
    logic       spp;    // 8
    logic       mpie;   // 7
    logic       rsv6;   // 6
    logic       spie;   // 5
    logic       rsv4;   // 4
    logic       mie;    // 3
    logic       rsv2;   // 2
    logic       sie;    // 1
    logic       rsv0;   // 0
  } csr_xstatus_t;

  localparam logic [11:0] CSR_SSTATUS   = 12'h100;
  localparam logic [11:0] CSR_STVEC     = 12'h105;
  localparam logic [11:0] CSR_SSCRATCH  = 12'h140;
  localparam logic [11:0] CSR_SEPC      = 12'h141;
  localparam logic [11:0] CSR_SCAUSE    = 12'h142;
  localparam logic [11:0] CSR_STVAL     = 12'h143;
  localparam logic [11:0] CSR_SATP      = 12'h180;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MEDELEG   = 12'h302;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  // SIE, MIE, SPIE, MPIE, SPP, MPP, SUM, MXR, TSR
  localparam logic [31:0] MSTATUS_MASK = 32'h004C_19AA;
  // SIE, SPIE, SPP, SUM, MXR
  localparam logic [31:0] SSTATUS_MASK = 32'h000C_0122;
  // Direct-mode vectors and word-aligned exception PCs
  localparam logic [31:0] XTVEC_MASK   = 32'hFFFF_FFFC;
  localparam logic [31:0] XEPC_MASK    = 32'hFFFF_FFFC;

  // MPP has no hypervisor level: the reserved encoding collapses to U.
  function automatic logic [1:0] legal_mpp(input logic [1:0] mpp);
    return (mpp == 2'b10) ? 2'b00 : mpp;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with per-half load.
//   clk, rst   : clock, asynchronous active-high reset (clears to 0)
//   inc_en     : add one this cycle (ignored when either half is loaded)
//   load_lo/hi : replace the low/high word with load_value
//   count      : current value, wraps 2^64 -> 0
module csr_counter64
  (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_en,
    input  logic        load_lo,
    input  logic        load_hi,
    input  logic [31:0] load_value,
    output logic [63:0] count
  );

  logic [63:0] count_d;
  logic [63:0] count_q;

  // Next count: a software load wins over the increment for that cycle.
  always_comb begin
    count_d = count_q;
    if (load_lo) begin
      count_d[31:0] = load_value;
    end else if (load_hi) begin
      count_d[63:32] = load_value;
    end else if (inc_en) begin
      count_d = count_q + 64'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Counter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 64'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/csr_unit.sv
// CSR file plus trap / privilege controller for the in-order RV32 core.
//   readAddr/readEnable -> readValue/readIllegal : combinational CSR read
//   writeEnable/writeAddr/writeValue             : CSR write commit
//   trapInfo/trapPc                              : trap entry
//   trapReturn/trapReturnPrivilege               : MRET (M) / SRET (S)
//   retire                                       : minstret increment
//   nextPc                                       : redirect target (0 when idle)
//   satp, mstatus, privilege, trapSupervisorReturn : current state
module csr_unit
  import ProcessorTypes::*;
  #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
  )
  (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] readAddr,
    input  logic        readEnable,
    output logic [31:0] readValue,
    output logic        readIllegal,
    input  logic        writeEnable,
    input  logic [11:0] writeAddr,
    input  logic [31:0] writeValue,
    input  TrapInfo     trapInfo,
    input  logic [31:0] trapPc,
    input  logic        trapReturn,
    input  Privilege    trapReturnPrivilege,
    input  logic        retire,
    output logic [31:0] nextPc,
    output logic [31:0] satp,
    output logic [31:0] mstatus,
    output logic [1:0]  privilege,
    output logic        trapSupervisorReturn
  );

  Privilege     priv_d, priv_q;
  csr_xstatus_t mstatus_d, mstatus_q;
  logic [31:0]  mtvec_d, mtvec_q, mepc_d, mepc_q, mcause_d, mcause_q;
  logic [31:0]  mtval_d, mtval_q, mscratch_d, mscratch_q;
  logic [31:0]  stvec_d, stvec_q, sepc_d, sepc_q, scause_d, scause_q;
  logic [31:0]  stval_d, stval_q, sscratch_d, sscratch_q, satp_d, satp_q;
  logic [15:0]  medeleg_d, medeleg_q;

  logic [1:0]   priv_bits_s;
  logic [31:0]  mstatus_bits_s;
  logic [31:0]  next_pc_s;
  logic         to_s_s;
  logic         cyc_ld_lo_s, cyc_ld_hi_s, ins_ld_lo_s, ins_ld_hi_s;
  logic [63:0]  mcycle_s, minstret_s;
  logic [31:0]  rd_val_s;
  logic         rd_hit_s;

  assign priv_bits_s    = priv_q;
  assign mstatus_bits_s = mstatus_q;

  // Architectural next state and redirect target; trap > return > write.
  always_comb begin
    priv_d      = priv_q;
    mstatus_d   = mstatus_q;
    mtvec_d     = mtvec_q;
    mepc_d      = mepc_q;
    mcause_d    = mcause_q;
    mtval_d     = mtval_q;
    mscratch_d  = mscratch_q;
    medeleg_d   = medeleg_q;
    stvec_d     = stvec_q;
    sepc_d      = sepc_q;
    scause_d    = scause_q;
    stval_d     = stval_q;
    sscratch_d  = sscratch_q;
    satp_d      = satp_q;
    next_pc_s   = 32'h0;
    cyc_ld_lo_s = 1'b0;
    cyc_ld_hi_s = 1'b0;
    ins_ld_lo_s = 1'b0;
    ins_ld_hi_s = 1'b0;
    // Only synchronous exceptions raised below M may be delegated to S.
    to_s_s = (priv_q != PRIV_M) && !trapInfo.isInterrupt && medeleg_q[trapInfo.cause];
    if (trapInfo.valid) begin
      if (to_s_s) begin
        sepc_d         = trapPc;
        scause_d       = {trapInfo.isInterrupt, 27'h0, trapInfo.cause};
        stval_d        = trapInfo.value;
        mstatus_d.spie = mstatus_q.sie;
        mstatus_d.sie  = 1'b0;
        mstatus_d.spp  = priv_bits_s[0];
        priv_d         = PRIV_S;
        next_pc_s      = stvec_q;
      end else begin
        mepc_d         = trapPc;
        mcause_d       = {trapInfo.isInterrupt, 27'h0, trapInfo.cause};
        mtval_d        = trapInfo.value;
        mstatus_d.mpie = mstatus_q.mie;
        mstatus_d.mie  = 1'b0;
        mstatus_d.mpp  = priv_bits_s;
        priv_d         = PRIV_M;
        next_pc_s      = mtvec_q;
      end
    end else if (trapReturn) begin
      case (trapReturnPrivilege)
        PRIV_M: begin
          // MPP can never hold 2'b10, so the cast always lands on a legal level.
          priv_d         = Privilege'(mstatus_q.mpp);
          mstatus_d.mie  = mstatus_q.mpie;
          mstatus_d.mpie = 1'b1;
          mstatus_d.mpp  = 2'b00;
          next_pc_s      = mepc_q;
        end
        default: begin
          priv_d         = Privilege'({1'b0, mstatus_q.spp});
          mstatus_d.sie  = mstatus_q.spie;
          mstatus_d.spie = 1'b1;
          mstatus_d.spp  = 1'b0;
          next_pc_s      = sepc_q;
        end
      endcase
    end else if (writeEnable) begin
      case (writeAddr)
        CSR_MSTATUS: begin
          mstatus_d     = csr_xstatus_t'(writeValue & MSTATUS_MASK);
          mstatus_d.mpp = legal_mpp(writeValue[12:11]);
        end
        CSR_SSTATUS:   mstatus_d  = csr_xstatus_t'((mstatus_bits_s & ~SSTATUS_MASK) |
                                                   (writeValue & SSTATUS_MASK));
        CSR_MTVEC:     mtvec_d    = writeValue & XTVEC_MASK;
        CSR_MEPC:      mepc_d     = writeValue & XEPC_MASK;
        CSR_MCAUSE:    mcause_d   = writeValue;
        CSR_MTVAL:     mtval_d    = writeValue;
        CSR_MSCRATCH:  mscratch_d = writeValue;
        CSR_MEDELEG:   medeleg_d  = writeValue[15:0];
        CSR_STVEC:     stvec_d    = writeValue & XTVEC_MASK;
        CSR_SEPC:      sepc_d     = writeValue & XEPC_MASK;
        CSR_SCAUSE:    scause_d   = writeValue;
        CSR_STVAL:     stval_d    = writeValue;
        CSR_SSCRATCH:  sscratch_d = writeValue;
        CSR_SATP:      satp_d     = writeValue;
        CSR_MCYCLE:    cyc_ld_lo_s = 1'b1;
        CSR_MCYCLEH:   cyc_ld_hi_s = 1'b1;
        CSR_MINSTRET:  ins_ld_lo_s = 1'b1;
        CSR_MINSTRETH: ins_ld_hi_s = 1'b1;
        default: ;
      endcase
    end else begin
      priv_d = priv_q;
    end
  end

  // CSR state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      priv_q     <= PRIV_M;
      mstatus_q  <= csr_xstatus_t'(32'h0);
      mtvec_q    <= RESET_PC;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      mtval_q    <= 32'h0;
      mscratch_q <= 32'h0;
      medeleg_q  <= 16'h0;
      stvec_q    <= RESET_PC;
      sepc_q     <= 32'h0;
      scause_q   <= 32'h0;
      stval_q    <= 32'h0;
      sscratch_q <= 32'h0;
      satp_q     <= 32'h0;
    end else begin
      priv_q     <= priv_d;
      mstatus_q  <= mstatus_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mscratch_q <= mscratch_d;
      medeleg_q  <= medeleg_d;
      stvec_q    <= stvec_d;
      sepc_q     <= sepc_d;
      scause_q   <= scause_d;
      stval_q    <= stval_d;
      sscratch_q <= sscratch_d;
      satp_q     <= satp_d;
    end
  end

  csr_counter64 u_mcycle (
    .clk(clk), .rst(rst), .inc_en(1'b1),
    .load_lo(cyc_ld_lo_s), .load_hi(cyc_ld_hi_s), .load_value(writeValue),
    .count(mcycle_s)
  );

  csr_counter64 u_minstret (
    .clk(clk), .rst(rst), .inc_en(retire),
    .load_lo(ins_ld_lo_s), .load_hi(ins_ld_hi_s), .load_value(writeValue),
    .count(minstret_s)
  );

  // Read address decode; rd_hit_s marks an implemented CSR.
  always_comb begin
    rd_val_s = 32'h0;
    rd_hit_s = 1'b1;
    case (readAddr)
      CSR_MSTATUS:                 rd_val_s = mstatus_bits_s;
      CSR_SSTATUS:                 rd_val_s = mstatus_bits_s & SSTATUS_MASK;
      CSR_MTVEC:                   rd_val_s = mtvec_q;
      CSR_MEPC:                    rd_val_s = mepc_q;
      CSR_MCAUSE:                  rd_val_s = mcause_q;
      CSR_MTVAL:                   rd_val_s = mtval_q;
      CSR_MSCRATCH:                rd_val_s = mscratch_q;
      CSR_MEDELEG:                 rd_val_s = {16'h0, medeleg_q};
      CSR_STVEC:                   rd_val_s = stvec_q;
      CSR_SEPC:                    rd_val_s = sepc_q;
      CSR_SCAUSE:                  rd_val_s = scause_q;
      CSR_STVAL:                   rd_val_s = stval_q;
      CSR_SSCRATCH:                rd_val_s = sscratch_q;
      CSR_SATP:                    rd_val_s = satp_q;
      CSR_MCYCLE, CSR_CYCLE:       rd_val_s = mcycle_s[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:     rd_val_s = mcycle_s[63:32];
      CSR_MINSTRET, CSR_INSTRET:   rd_val_s = minstret_s[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rd_val_s = minstret_s[63:32];
      default:                     rd_hit_s = 1'b0;
    endcase
  end

  // Address bits [9:8] carry the lowest privilege allowed to access the CSR.
  assign readIllegal = readEnable && (!rd_hit_s || (readAddr[9:8] > priv_bits_s));
  assign readValue   = (readEnable && !readIllegal) ? rd_val_s : 32'h0;

  assign nextPc               = next_pc_s;
  assign satp                 = satp_q;
  assign mstatus              = mstatus_bits_s;
  assign privilege            = priv_bits_s;
  assign trapSupervisorReturn = mstatus_q.tsr;

endmodule

// File: tb/tb_csr_unit.sv
// Scoreboard bench for csr_unit: stimulus pushes expected values, a monitor
// on the falling edge pops and compares them against the DUT outputs.
module tb_csr_unit;
  import ProcessorTypes::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] readAddr;
  logic        readEnable;
  logic [31:0] readValue;
  logic        readIllegal;
  logic        writeEnable;
  logic [11:0] writeAddr;
  logic [31:0] writeValue;
  TrapInfo     trapInfo;
  logic [31:0] trapPc;
  logic        trapReturn;
  Privilege    trapReturnPrivilege;
  logic        retire;
  logic [31:0] nextPc;
  logic [31:0] satp;
  logic [31:0] mstatus;
  logic [1:0]  privilege;
  logic        trapSupervisorReturn;

  csr_unit #(.RESET_PC(32'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .readAddr(readAddr), .readEnable(readEnable),
    .readValue(readValue), .readIllegal(readIllegal),
    .writeEnable(writeEnable), .writeAddr(writeAddr), .writeValue(writeValue),
    .trapInfo(trapInfo), .trapPc(trapPc),
    .trapReturn(trapReturn), .trapReturnPrivilege(trapReturnPrivilege),
    .retire(retire), .nextPc(nextPc), .satp(satp), .mstatus(mstatus),
    .privilege(privilege), .trapSupervisorReturn(trapSupervisorReturn)
  );

  always #5 clk = ~clk;

  localparam int SEL_RD = 0, SEL_ILL = 1, SEL_NPC = 2, SEL_PRV = 3;
  localparam int SEL_MST = 4, SEL_SATP = 5, SEL_TSR = 6;

  typedef struct {
    int          sel;
    string       name;
    logic [31:0] value;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic idle();
    readEnable = 1'b0; readAddr = 12'h0;
    writeEnable = 1'b0; writeAddr = 12'h0; writeValue = 32'h0;
    trapInfo = '0; trapPc = 32'h0;
    trapReturn = 1'b0; trapReturnPrivilege = PRIV_M;
    retire = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic chk(input int sel, input string name, input logic [31:0] v);
    exp_q.push_back('{sel, name, v});
  endtask

  task automatic rd(input logic [11:0] a, input string name, input logic [31:0] v);
    readEnable = 1'b1; readAddr = a;
    chk(SEL_RD, name, v);
    chk(SEL_ILL, {name, "_ill"}, 32'd0);
  endtask

  task automatic ill(input logic [11:0] a, input string name);
    readEnable = 1'b1; readAddr = a;
    chk(SEL_ILL, name, 32'd1);
    chk(SEL_RD, {name, "_val"}, 32'd0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] v);
    writeEnable = 1'b1; writeAddr = a; writeValue = v;
  endtask

  task automatic trap(input logic [3:0] c, input logic [31:0] val, input logic [31:0] pc);
    trapInfo = {1'b1, 1'b0, c, val};
    trapPc = pc;
  endtask

  task automatic ret(input Privilege p);
    trapReturn = 1'b1; trapReturnPrivilege = p;
  endtask

  // Monitor: drain every expectation queued for this cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.sel)
        SEL_RD:   act = readValue;
        SEL_ILL:  act = {31'd0, readIllegal};
        SEL_NPC:  act = nextPc;
        SEL_PRV:  act = {30'd0, privilege};
        SEL_MST:  act = mstatus;
        SEL_SATP: act = satp;
        default:  act = {31'd0, trapSupervisorReturn};
      endcase
      total++;
      if (act !== e.value) begin
        bad++;
        $display("FAIL %s: got=%h want=%h", e.name, act, e.value);
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    // reset state
    rd(CSR_MTVEC, "rst_mtvec", 32'h8000_0000);
    chk(SEL_PRV, "rst_priv", 32'd3);
    chk(SEL_MST, "rst_mstatus", 32'h0);
    chk(SEL_SATP, "rst_satp", 32'h0);
    chk(SEL_NPC, "rst_npc", 32'h0);
    tick(); rst = 1'b0;
    rd(CSR_MCYCLE, "mcycle0", 32'd0); chk(SEL_PRV, "priv_after_rst", 32'd3);
    tick(); rd(CSR_MCYCLE, "mcycle1", 32'd1);
    tick(); rd(CSR_MCYCLE, "mcycle2", 32'd2);
    tick(); rd(CSR_MCYCLE, "mcycle3", 32'd3);
    // write mepc, no bypass, low bits masked
    tick(); wr(CSR_MEPC, 32'h1234_5677); rd(CSR_MEPC, "mepc_same_cycle", 32'h0);
    tick(); rd(CSR_MEPC, "mepc_masked", 32'h1234_5674);
    // get to S via MRET, then delegated trap
    tick(); wr(CSR_MEDELEG, 32'h0000_0100);
    tick(); wr(CSR_STVEC, 32'h0000_0100);
    tick(); wr(CSR_MSTATUS, 32'h0000_0800);
    tick(); ret(PRIV_M); chk(SEL_NPC, "mret_to_s_npc", 32'h1234_5674);
    tick(); chk(SEL_PRV, "priv_s", 32'd1); chk(SEL_MST, "mst_after_mret_s", 32'h0000_0080);
    trap(4'd8, 32'hDEAD_BEEF, 32'h0000_4000); chk(SEL_NPC, "strap_npc", 32'h0000_0100);
    tick(); chk(SEL_PRV, "strap_priv", 32'd1); chk(SEL_MST, "strap_mst", 32'h0000_0180);
    rd(CSR_SEPC, "sepc", 32'h0000_4000);
    tick(); rd(CSR_SCAUSE, "scause", 32'd8);
    tick(); rd(CSR_STVAL, "stval", 32'hDEAD_BEEF);
    // get to U with MIE=1, then non-delegated trap to M, then MRET
    tick(); wr(CSR_MSTATUS, 32'h0000_0080);
    tick(); ret(PRIV_M); chk(SEL_NPC, "mret_to_u_npc", 32'h1234_5674);
    tick(); chk(SEL_PRV, "priv_u", 32'd0); chk(SEL_MST, "mst_u", 32'h0000_0088);
    trap(4'd2, 32'h0000_0013, 32'h0000_2000); chk(SEL_NPC, "mtrap_npc", 32'h8000_0000);
    tick(); chk(SEL_PRV, "mtrap_priv", 32'd3); chk(SEL_MST, "mtrap_mst", 32'h0000_0080);
    rd(CSR_MEPC, "mtrap_mepc", 32'h0000_2000);
    tick(); rd(CSR_MCAUSE, "mtrap_mcause", 32'd2);
    tick(); rd(CSR_MTVAL, "mtrap_mtval", 32'h0000_0013);
    ret(PRIV_M); chk(SEL_NPC, "mret_npc", 32'h0000_2000);
    tick(); chk(SEL_PRV, "mret_priv", 32'd0); chk(SEL_MST, "mret_mst", 32'h0000_0088);
    wr(CSR_MSCRATCH, 32'hAAAA_5555);
    // trap, return and write together: only the trap lands
    tick(); trap(4'd3, 32'h0, 32'h0000_3000); ret(PRIV_M); wr(CSR_MSCRATCH, 32'h1111_1111);
    chk(SEL_NPC, "coinc_npc", 32'h8000_0000);
    tick(); chk(SEL_PRV, "coinc_priv", 32'd3); chk(SEL_MST, "coinc_mst", 32'h0000_0080);
    rd(CSR_MSCRATCH, "coinc_mscratch", 32'hAAAA_5555);
    tick(); rd(CSR_MEPC, "coinc_mepc", 32'h0000_3000);
    tick(); rd(CSR_MCAUSE, "coinc_mcause", 32'd3);
    // minstret wrap
    tick(); wr(CSR_MINSTRET, 32'hFFFF_FFFF);
    tick(); wr(CSR_MINSTRETH, 32'hFFFF_FFFF); rd(CSR_MINSTRET, "minstret_lo_ld", 32'hFFFF_FFFF);
    tick(); retire = 1'b1; rd(CSR_MINSTRETH, "minstret_hi_ld", 32'hFFFF_FFFF);
    tick(); rd(CSR_MINSTRET, "minstret_wrap_lo", 32'h0);
    tick(); rd(CSR_MINSTRETH, "minstret_wrap_hi", 32'h0);
    tick(); rd(CSR_INSTRET, "instret_alias", 32'h0);
    // mcycle load suppresses that cycle's increment
    tick(); wr(CSR_MCYCLE, 32'h0000_0010);
    tick(); rd(CSR_MCYCLE, "mcycle_ld", 32'h0000_0010);
    tick(); rd(CSR_MCYCLE, "mcycle_ld_inc", 32'h0000_0011);
    // field masks and outputs
    tick(); wr(CSR_MTVEC, 32'h8000_0103);
    tick(); rd(CSR_MTVEC, "mtvec_masked", 32'h8000_0100); wr(CSR_SATP, 32'h8000_1234);
    tick(); chk(SEL_SATP, "satp_out", 32'h8000_1234); wr(CSR_MSTATUS, 32'h0040_1000);
    tick(); chk(SEL_MST, "mpp10_to_u", 32'h0040_0000); chk(SEL_TSR, "tsr_set", 32'd1);
    wr(CSR_MSTATUS, 32'h0004_0802);
    tick(); ret(PRIV_M); chk(SEL_NPC, "mret3_npc", 32'h0000_3000);
    tick(); chk(SEL_PRV, "priv_s2", 32'd1); chk(SEL_MST, "mst_s2", 32'h0004_0082);
    ill(CSR_MSTATUS, "mstatus_from_s");
    tick(); ill(12'h7C0, "unimpl_7c0");
    tick(); rd(CSR_SSTATUS, "sstatus_view", 32'h0004_0002);
    tick(); wr(CSR_SSTATUS, 32'hFFFF_FFFF);
    tick(); chk(SEL_MST, "sstatus_write", 32'h000C_01A2); chk(SEL_TSR, "tsr_clear", 32'd0);
    // reset mid-cycle during a trap: trap lost
    tick(); trap(4'd1, 32'h55, 32'h0000_5000); #2; rst = 1'b1;
    chk(SEL_PRV, "rst_mid_priv", 32'd3); chk(SEL_MST, "rst_mid_mst", 32'h0);
    tick(); rst = 1'b0;
    chk(SEL_PRV, "post_rst_priv", 32'd3); rd(CSR_MEPC, "post_rst_mepc", 32'h0);
    tick();
    @(posedge clk); #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
